// File: rtl/capture_display_ctrl_if.sv
// Bundle of the capture/display control signals between the switch, LFSR and
// register-file side (master) and the controller (slave).
interface capture_display_ctrl_if;
    logic [1:0]  rate_i;
    logic        cap_i;
    logic        slot_i;
    logic        rnd_valid_i;
    logic [15:0] rnd_i;
    logic [1:0]  reg_we_o;
    logic [15:0] reg_data_o;
    logic        disp_sel_o;
    logic        tick_o;
    logic        busy_o;
    logic        err_o;

    modport master (
        output rate_i, cap_i, slot_i, rnd_valid_i, rnd_i,
        input  reg_we_o, reg_data_o, disp_sel_o, tick_o, busy_o, err_o
    );

    modport slave (
        input  rate_i, cap_i, slot_i, rnd_valid_i, rnd_i,
        output reg_we_o, reg_data_o, disp_sel_o, tick_o, busy_o, err_o
    );
endinterface

// File: rtl/capture_display_ctrl.sv
// capture_display_ctrl: on a switch press, waits for the next random word and
// writes it into one of two display registers, giving up after a timeout.
// Independently, alternates the display mux between the two registers at a
// rate chosen by rate_i.
module capture_display_ctrl #(
    parameter logic [27:0] T_HALF = 28'd5_000_000,
    parameter logic [27:0] T_ONE  = 28'd10_000_000,
    parameter logic [27:0] T_TWO  = 28'd20_000_000,
    parameter logic [27:0] T_TMO  = 28'd25_000_000
) (
    input logic                   clk_i,
    input logic                   rst_i,
    capture_display_ctrl_if.slave bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;

    logic [1:0]  state;
    logic        cap_q;
    logic        first_q;
    logic        slot_q;
    logic        err_q;
    logic [27:0] tmo_cnt;
    logic [15:0] data_q;
    logic        request;

    logic [1:0]  rate_q;
    logic [27:0] per_cnt;
    logic [27:0] per_len;
    logic        tick_q;
    logic        sel_q;

    // A switch already high when reset releases must not count as a press, so
    // the first post-reset cycle only loads cap_q.
    assign request = bus.cap_i & ~cap_q & ~first_q;

    // Capture sequencer: arm on a press, take the next random word, write it once.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= S_IDLE;
            cap_q   <= 1'b0;
            first_q <= 1'b1;
            slot_q  <= 1'b0;
            err_q   <= 1'b0;
            tmo_cnt <= 28'd0;
            data_q  <= 16'd0;
        end else begin
            cap_q   <= bus.cap_i;
            first_q <= 1'b0;
            err_q   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (request) begin
                        slot_q  <= bus.slot_i;
                        tmo_cnt <= 28'd0;
                        state   <= S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (bus.rnd_valid_i) begin
                        data_q <= bus.rnd_i;
                        state  <= S_WRITE;
                    end else if (tmo_cnt == T_TMO - 28'd1) begin
                        err_q <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 28'd1;
                    end
                end
                S_WRITE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy_o     = (state != S_IDLE);
    assign bus.reg_we_o   = (state == S_WRITE) ? (slot_q ? 2'b10 : 2'b01) : 2'b00;
    assign bus.reg_data_o = data_q;
    assign bus.err_o      = err_q;

    // Period length for the currently registered rate; zero means hold.
    always_comb begin
        per_len = 28'd0;
        case (rate_q)
            2'b01:   per_len = T_TWO;
            2'b10:   per_len = T_ONE;
            2'b11:   per_len = T_HALF;
            default: per_len = 28'd0;
        endcase
    end

    // Display period counter: a rate change restarts the period from zero.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rate_q  <= 2'b00;
            per_cnt <= 28'd0;
            tick_q  <= 1'b0;
            sel_q   <= 1'b0;
        end else begin
            rate_q <= bus.rate_i;
            tick_q <= 1'b0;
            if ((bus.rate_i != rate_q) || (rate_q == 2'b00)) begin
                per_cnt <= 28'd0;
            end else if (per_cnt == per_len - 28'd1) begin
                per_cnt <= 28'd0;
                tick_q  <= 1'b1;
                sel_q   <= ~sel_q;
            end else begin
                per_cnt <= per_cnt + 28'd1;
            end
        end
    end

    assign bus.tick_o     = tick_q;
    assign bus.disp_sel_o = sel_q;

endmodule

// File: tb/tb_capture_display_ctrl.sv
// Testbench for capture_display_ctrl: directed scenarios followed by random
// traffic, predicted by a cycle-indexed event model and checked by a monitor.
module tb_capture_display_ctrl;

    localparam int TMO = 8;

    typedef struct {
        int          at;
        bit          chk;
        bit          busy;
        bit          sel;
        logic [15:0] data;
    } cyc_exp_t;

    typedef struct {
        int          at;
        logic [1:0]  we;
        logic [15:0] data;
    } wr_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = -1;

    int passed = 0;
    int total  = 0;

    cyc_exp_t cycq[$];
    wr_exp_t  wq[$];
    int       eq[$];
    int       tq[$];

    // Inputs held between steps
    bit         cur_cap  = 1'b0;
    bit         cur_slot = 1'b0;
    logic [1:0] cur_rate = 2'b00;

    // Reference model state: a capture is "accepted at m_acc" and later
    // resolved either by a write or a timeout ending at m_end.
    bit          m_pend = 1'b0;
    bit          m_res = 1'b0;
    int          m_acc = 0;
    int          m_end = 0;
    bit          m_slot = 1'b0;
    bit          m_first = 1'b1;
    bit          m_prev_cap = 1'b0;
    logic [1:0]  m_prev_rate = 2'b00;
    int          m_start = 0;
    int          m_len = 0;
    bit          m_sel_nx = 1'b0;
    logic [15:0] m_data_nx = 16'd0;
    bit          m_chk_nx = 1'b0;

    capture_display_ctrl_if bus();

    capture_display_ctrl #(
        .T_HALF(28'd5),
        .T_ONE (28'd10),
        .T_TWO (28'd20),
        .T_TMO (28'd8)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int rateLen(input logic [1:0] r);
        case (r)
            2'b01:   return 20;
            2'b10:   return 10;
            2'b11:   return 5;
            default: return 0;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s cycle %0d: got %0h, required %0h", name, cyc, act, exp);
    endtask

    // Drive one cycle of inputs and advance the reference model by that cycle.
    task automatic applyStimulus(input bit r, input bit v, input logic [15:0] d);
        cyc_exp_t ce;
        bit       rise;
        int       k;
        @(posedge clk);
        #1;
        rst             = r;
        bus.cap_i       = cur_cap;
        bus.slot_i      = cur_slot;
        bus.rnd_valid_i = v;
        bus.rnd_i       = d;
        bus.rate_i      = cur_rate;
        k = cyc;

        if (m_pend && m_res && k > m_end) m_pend = 1'b0;
        ce.at   = k;
        ce.chk  = m_chk_nx;
        ce.busy = m_pend;
        ce.sel  = m_sel_nx;
        ce.data = m_data_nx;
        cycq.push_back(ce);

        if (r) begin
            m_pend      = 1'b0;
            m_first     = 1'b1;
            m_prev_cap  = 1'b0;
            m_prev_rate = 2'b00;
            m_len       = 0;
            m_sel_nx    = 1'b0;
            m_data_nx   = 16'd0;
            m_chk_nx    = 1'b1;
        end else begin
            rise       = cur_cap && !m_prev_cap && !m_first;
            m_first    = 1'b0;
            m_prev_cap = cur_cap;
            if (m_pend && !m_res) begin
                if (v) begin
                    wr_exp_t w;
                    m_res     = 1'b1;
                    m_end     = k + 1;
                    m_data_nx = d;
                    w.at   = k + 1;
                    w.we   = m_slot ? 2'b10 : 2'b01;
                    w.data = d;
                    wq.push_back(w);
                end else if (k == m_acc + TMO) begin
                    m_res = 1'b1;
                    m_end = k;
                    eq.push_back(k + 1);
                end
            end
            if (!m_pend && rise) begin
                m_pend = 1'b1;
                m_res  = 1'b0;
                m_acc  = k;
                m_slot = cur_slot;
            end
            if (cur_rate != m_prev_rate) begin
                m_start = k + 1;
                m_len   = rateLen(cur_rate);
            end else if (m_len != 0 && (k + 1) > m_start && ((k + 1 - m_start) % m_len) == 0) begin
                tq.push_back(k + 1);
                m_sel_nx = !m_sel_nx;
            end
            m_prev_rate = cur_rate;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 16'd0);
    endtask

    task automatic randomCycle(input int rst_odds);
        bit r;
        if ($urandom_range(5) == 0) cur_cap = ~cur_cap;
        cur_slot = 1'($urandom_range(1));
        r = (rst_odds > 0) && ($urandom_range(rst_odds - 1) == 0);
        applyStimulus(r, ($urandom_range(4) == 0), 16'($urandom()));
    endtask

    // Monitor: compares every cycle's outputs against the expectations queued
    // by the stimulus side for that cycle.
    cyc_exp_t   mon_e;
    logic [1:0] mon_we;
    bit         mon_err;
    bit         mon_tick;

    always @(negedge clk) begin
        if (cycq.size() > 0) begin
            mon_e    = cycq.pop_front();
            mon_we   = 2'b00;
            mon_err  = 1'b0;
            mon_tick = 1'b0;
            if (wq.size() > 0 && wq[0].at == mon_e.at) begin
                mon_we = wq[0].we;
                void'(wq.pop_front());
            end
            if (eq.size() > 0 && eq[0] == mon_e.at) begin
                mon_err = 1'b1;
                void'(eq.pop_front());
            end
            if (tq.size() > 0 && tq[0] == mon_e.at) begin
                mon_tick = 1'b1;
                void'(tq.pop_front());
            end
            if (mon_e.chk) begin
                checkOutput("busy", bus.busy_o, mon_e.busy);
                checkOutput("disp_sel", bus.disp_sel_o, mon_e.sel);
                checkOutput("reg_data", bus.reg_data_o, mon_e.data);
                checkOutput("reg_we", bus.reg_we_o, mon_we);
                checkOutput("err", bus.err_o, mon_err);
                checkOutput("tick", bus.tick_o, mon_tick);
            end
        end
    end

    initial begin
        bus.cap_i       = 1'b0;
        bus.slot_i      = 1'b0;
        bus.rnd_valid_i = 1'b0;
        bus.rnd_i       = 16'd0;
        bus.rate_i      = 2'b11;

        // Reset with the fast display rate already selected
        cur_rate = 2'b11;
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 16'd0);

        // Capture into register 2 with the random word four cycles after the press
        cur_slot = 1'b1;
        cur_cap  = 1'b1;
        idle(4);
        applyStimulus(1'b0, 1'b1, 16'hBEEF);
        cur_cap = 1'b0;
        idle(4);

        // Capture that never sees a random word times out
        cur_slot = 1'b0;
        cur_cap  = 1'b1;
        idle(2);
        cur_cap = 1'b0;
        idle(12);

        // Second press while busy is discarded; slot change after acceptance ignored
        cur_cap = 1'b1;
        idle(1);
        cur_cap = 1'b0;
        idle(1);
        cur_cap  = 1'b1;
        cur_slot = 1'b1;
        idle(1);
        cur_slot = 1'b0;
        applyStimulus(1'b0, 1'b1, 16'h1234);
        cur_cap = 1'b0;
        idle(4);

        // Rate change restarts the display period
        cur_rate = 2'b10;
        idle(35);

        // Reset while armed with the switch held: no write, no re-trigger
        cur_slot = 1'b1;
        cur_cap  = 1'b1;
        idle(3);
        applyStimulus(1'b1, 1'b0, 16'd0);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, 16'($urandom()));
        cur_cap = 1'b0;
        idle(2);
        cur_cap = 1'b1;
        idle(2);
        applyStimulus(1'b0, 1'b1, 16'hCAFE);
        cur_cap = 1'b0;
        idle(3);

        // Hold rate: display frozen while captures continue
        cur_rate = 2'b00;
        for (int i = 0; i < 100; i++) randomCycle(0);

        // Random traffic with occasional resets and rate changes
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(59) == 0) cur_rate = 2'($urandom_range(3));
            randomCycle(200);
        end

        // Drain outstanding captures with the display held
        cur_cap  = 1'b0;
        cur_rate = 2'b00;
        idle(15);
        repeat (2) @(negedge clk);
        #1;
        checkOutput("write_queue_empty", wq.size(), 0);
        checkOutput("err_queue_empty", eq.size(), 0);
        checkOutput("tick_queue_empty", tq.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
